// File: rtl/data_pipe_interconnect_1ton_if.sv
// Stream bundle between one producer and NUM_M consumers of the 1-to-N pipe.
// The data bus is one word per channel; every slice carries the same word.
interface data_pipe_interconnect_1ton_if #(
  parameter int DSIZE = 8,
  parameter int NUM_M = 8
);
  logic                        s_valid;
  logic [DSIZE-1:0]            s_data;
  logic                        s_ready;
  logic [NUM_M-1:0]            m_valid;
  logic [NUM_M-1:0][DSIZE-1:0] m_data;
  logic [NUM_M-1:0]            m_ready;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/data_pipe_interconnect_1ton.sv
// 1-to-N switched data pipe: output register plus skid entry, path latched only
// while empty, invalid path either drops (counted) or stalls until re-selected.
module data_pipe_interconnect_1ton_lane #(
  parameter int DSIZE = 8,
  parameter int PW    = 3,
  parameter int LANE  = 0
) (
  input  logic [PW-1:0]    path,
  input  logic             path_ok,
  input  logic             out_vld,
  input  logic             m_ready,
  input  logic [DSIZE-1:0] data,
  output logic             m_valid,
  output logic             rdy,
  output logic [DSIZE-1:0] m_data
);
  logic hit;
  assign hit     = path_ok & (path == PW'(LANE));
  assign m_valid = out_vld & hit;
  assign rdy     = hit & m_ready;
  assign m_data  = data;
endmodule

module data_pipe_interconnect_1ton #(
  parameter int DSIZE        = 8,
  parameter int NUM_M        = 8,
  parameter int PW           = $clog2(NUM_M),
  parameter bit DROP_INVALID = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 sw_vld,
  input  logic [PW-1:0]        sw,
  data_pipe_interconnect_1ton_if.slave bus,
  output logic [PW-1:0]        curr_path,
  output logic                 path_ok,
  output logic                 busy,
  output logic [CNT_W-1:0]     drop_cnt
);
  logic             init_q;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [DSIZE-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [PW-1:0]    path_q, path_d;
  logic             pok_q, pok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_M-1:0]            lane_rdy, lane_vld;
  logic [NUM_M-1:0][DSIZE-1:0] lane_data;
  logic                        sel_rdy, acc, pop, load;

  for (genvar i = 0; i < NUM_M; i++) begin : g_lane
    data_pipe_interconnect_1ton_lane #(.DSIZE(DSIZE), .PW(PW), .LANE(i)) u_lane (
      .path    (path_q),
      .path_ok (pok_q),
      .out_vld (out_vld_q),
      .m_ready (bus.m_ready[i]),
      .data    (out_data_q),
      .m_valid (lane_vld[i]),
      .rdy     (lane_rdy[i]),
      .m_data  (lane_data[i])
    );
  end

  assign bus.s_ready = init_q & ~skid_vld_q;
  assign bus.m_valid = lane_vld;
  assign bus.m_data  = lane_data;
  assign busy        = out_vld_q | skid_vld_q;
  assign curr_path   = path_q;
  assign path_ok     = pok_q;
  assign drop_cnt    = cnt_q;

  assign sel_rdy = pok_q ? (|lane_rdy) : DROP_INVALID;
  assign acc     = bus.s_valid & bus.s_ready & clk_en;
  assign pop     = out_vld_q & sel_rdy & clk_en;
  // A stalled invalid path keeps re-sampling sw so it can be escaped while full.
  assign load    = clk_en & (~busy | (~pok_q & ~DROP_INVALID));

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    path_d      = path_q;
    pok_d       = pok_q;
    cnt_d       = cnt_q;
    if (acc && (!out_vld_q || pop)) begin
      out_vld_d  = 1'b1;
      out_data_d = bus.s_data;
    end else if (acc) begin
      skid_vld_d  = 1'b1;
      skid_data_d = bus.s_data;
    end else if (pop && skid_vld_q) begin
      out_data_d = skid_data_q;
      skid_vld_d = 1'b0;
    end else if (pop) begin
      out_vld_d = 1'b0;
    end
    if (load) begin
      path_d = sw;
      pok_d  = sw_vld && (32'(sw) < NUM_M);
    end
    if (pop && !pok_q && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      init_q      <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      path_q      <= '0;
      pok_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (clk_en) begin
      init_q      <= 1'b1;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      path_q      <= path_d;
      pok_q       <= pok_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_data_pipe_interconnect_1ton.sv
// Directed bench: 8-channel pipe for streaming/backpressure/switch/enable/reset,
// three 6-channel pipes on an invalid path for drop, saturation and stall policies.
module tb_data_pipe_interconnect_1ton;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // 8-channel instance
  logic        rst8, ce8, swv8;
  logic [2:0]  sw8, cp8;
  logic        pok8, busy8;
  logic [15:0] dc8;
  data_pipe_interconnect_1ton_if #(.DSIZE(8), .NUM_M(8)) b8 ();
  data_pipe_interconnect_1ton #(.DSIZE(8), .NUM_M(8), .DROP_INVALID(1'b1), .CNT_W(16)) u8 (
    .clock(clock), .rst(rst8), .clk_en(ce8), .sw_vld(swv8), .sw(sw8), .bus(b8),
    .curr_path(cp8), .path_ok(pok8), .busy(busy8), .drop_cnt(dc8));

  // 6-channel instances sharing one stimulus
  logic       rst6, ce6, swv6, sv6;
  logic [2:0] sw6;
  logic [7:0] d6;
  logic [5:0] mr6;
  logic [2:0] cp6d, cp6c, cp6s;
  logic       pok6d, pok6c, pok6s, busy6d, busy6c, busy6s;
  logic [15:0] dc6d, dc6s;
  logic [1:0]  dc6c;
  data_pipe_interconnect_1ton_if #(.DSIZE(8), .NUM_M(6)) b6d ();
  data_pipe_interconnect_1ton_if #(.DSIZE(8), .NUM_M(6)) b6c ();
  data_pipe_interconnect_1ton_if #(.DSIZE(8), .NUM_M(6)) b6s ();
  assign b6d.s_valid = sv6; assign b6d.s_data = d6; assign b6d.m_ready = mr6;
  assign b6c.s_valid = sv6; assign b6c.s_data = d6; assign b6c.m_ready = mr6;
  assign b6s.s_valid = sv6; assign b6s.s_data = d6; assign b6s.m_ready = mr6;

  data_pipe_interconnect_1ton #(.DSIZE(8), .NUM_M(6), .DROP_INVALID(1'b1), .CNT_W(16)) u6d (
    .clock(clock), .rst(rst6), .clk_en(ce6), .sw_vld(swv6), .sw(sw6), .bus(b6d),
    .curr_path(cp6d), .path_ok(pok6d), .busy(busy6d), .drop_cnt(dc6d));
  data_pipe_interconnect_1ton #(.DSIZE(8), .NUM_M(6), .DROP_INVALID(1'b1), .CNT_W(2)) u6c (
    .clock(clock), .rst(rst6), .clk_en(ce6), .sw_vld(swv6), .sw(sw6), .bus(b6c),
    .curr_path(cp6c), .path_ok(pok6c), .busy(busy6c), .drop_cnt(dc6c));
  data_pipe_interconnect_1ton #(.DSIZE(8), .NUM_M(6), .DROP_INVALID(1'b0), .CNT_W(16)) u6s (
    .clock(clock), .rst(rst6), .clk_en(ce6), .sw_vld(swv6), .sw(sw6), .bus(b6s),
    .curr_path(cp6s), .path_ok(pok6s), .busy(busy6s), .drop_cnt(dc6s));

  logic [7:0] rx [0:15];
  logic       srh [0:15];
  int         idx, n;

  task automatic chk_reset8(input string tag);
    chk({tag, "_srdy"}, b8.s_ready, 0);
    chk({tag, "_mvld"}, b8.m_valid, 0);
    chk({tag, "_mdat"}, b8.m_data, 0);
    chk({tag, "_path"}, cp8, 0);
    chk({tag, "_pok"},  pok8, 0);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_cnt"},  dc8, 0);
  endtask

  initial begin
    rst8 = 1; ce8 = 1; swv8 = 1; sw8 = 3;
    b8.s_valid = 0; b8.s_data = 0; b8.m_ready = '1;
    rst6 = 1; ce6 = 1; swv6 = 1; sw6 = 7; sv6 = 0; d6 = 0; mr6 = 0;
    repeat (2) @(negedge clock);
    chk_reset8("rst");
    rst8 = 0;
    @(negedge clock);
    chk("init_srdy", b8.s_ready, 1);
    chk("init_path", cp8, 3);
    chk("init_pok", pok8, 1);

    // streaming 0x01..0x10 on channel 3
    b8.s_valid = 1; b8.s_data = 8'h01;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk("str_vld", b8.m_valid, 8'h08);
      chk("str_dat", b8.m_data, {8{8'(k)}});
      if (k < 16) b8.s_data = 8'(k + 1);
      else b8.s_valid = 0;
    end
    @(negedge clock);
    chk("str_idle_vld", b8.m_valid, 0);
    chk("str_idle_busy", busy8, 0);

    // backpressure: m_ready[3] low for 4 cycles
    idx = 0; n = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      b8.m_ready[3] = !(t >= 3 && t <= 6);
      b8.s_valid = (idx < 8);
      b8.s_data = 8'hA0 + 8'(idx);
      #1;
      srh[t] = b8.s_ready;
      if (t >= 4 && t <= 6) chk("bp_hold", {b8.m_valid, b8.m_data[3]}, {8'h08, 8'hA2});
      if (b8.m_valid[3] && b8.m_ready[3]) begin rx[n] = b8.m_data[3]; n++; end
      if (b8.s_valid && b8.s_ready) idx++;
    end
    b8.s_valid = 0;
    chk("bp_srdy_t3", srh[3], 1);
    chk("bp_srdy_t4", srh[4], 0);
    chk("bp_srdy_t7", srh[7], 0);
    chk("bp_srdy_t8", srh[8], 1);
    chk("bp_count", n, 8);
    for (int i = 0; i < 8; i++) chk("bp_order", rx[i], 8'hA0 + 8'(i));

    // switch 3 -> 5 with two beats buffered
    @(negedge clock);
    b8.m_ready[3] = 0; b8.s_valid = 1; b8.s_data = 8'hB0;
    @(negedge clock);
    b8.s_data = 8'hB1;
    @(negedge clock);
    b8.s_valid = 0; sw8 = 5;
    @(negedge clock);
    chk("sw_busy", busy8, 1);
    chk("sw_path_a", cp8, 3);
    chk("sw_b0", {b8.m_valid, b8.m_data[3]}, {8'h08, 8'hB0});
    b8.m_ready[3] = 1;
    @(negedge clock);
    chk("sw_b1", {b8.m_valid, b8.m_data[3]}, {8'h08, 8'hB1});
    chk("sw_path_b", cp8, 3);
    @(negedge clock);
    chk("sw_empty", busy8, 0);
    chk("sw_path_c", cp8, 3);
    b8.s_valid = 1; b8.s_data = 8'hC0;
    @(negedge clock);
    b8.s_valid = 0;
    chk("sw_path_new", cp8, 5);
    chk("sw_c0", {b8.m_valid, b8.m_data[5]}, {8'h20, 8'hC0});
    @(negedge clock);
    chk("sw_drain", busy8, 0);

    // clk_en toggling every other cycle
    idx = 0; n = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clock);
      ce8 = (t % 2 == 0);
      b8.s_valid = (idx < 4);
      b8.s_data = 8'h40 + 8'(idx);
      #1;
      if (t == 1 || t == 2) chk("ce_hold", {b8.m_valid, b8.m_data[5]}, {8'h20, 8'h40});
      if (ce8 && b8.m_valid[5] && b8.m_ready[5]) begin rx[n] = b8.m_data[5]; n++; end
      if (ce8 && b8.s_valid && b8.s_ready) idx++;
    end
    ce8 = 1; b8.s_valid = 0;
    chk("ce_count", n, 4);
    for (int i = 0; i < 4; i++) chk("ce_order", rx[i], 8'h40 + 8'(i));
    chk("ce_nodrop", dc8, 0);

    // reset with the skid full
    @(negedge clock);
    b8.m_ready = '0; b8.s_valid = 1; b8.s_data = 8'hD0;
    @(negedge clock);
    b8.s_data = 8'hD1;
    @(negedge clock);
    b8.s_valid = 0;
    chk("full_busy", busy8, 1);
    chk("full_srdy", b8.s_ready, 0);
    rst8 = 1;
    @(negedge clock);
    chk_reset8("midrst");
    rst8 = 0; ce8 = 0;
    @(negedge clock);
    chk("rel_noen_srdy", b8.s_ready, 0);
    ce8 = 1;
    @(negedge clock);
    chk("rel_srdy", b8.s_ready, 1);

    // invalid path sw=7 on 6 channels
    rst6 = 0;
    @(negedge clock);
    chk("inv_pok", pok6d, 0);
    chk("inv_path", cp6d, 7);
    for (int t = 0; t < 8; t++) begin
      sv6 = (t < 6);
      d6 = 8'hE0 + 8'(t);
      #1;
      chk("inv_mvld_d", b6d.m_valid, 0);
      chk("inv_mvld_s", b6s.m_valid, 0);
      if (t < 6) chk("inv_srdy_d", b6d.s_ready, 1);
      if (t == 1) chk("stall_srdy_1", b6s.s_ready, 1);
      if (t == 2) chk("stall_srdy_2", b6s.s_ready, 0);
      if (t == 6) chk("drop_cnt5", dc6d, 5);
      @(negedge clock);
    end
    sv6 = 0;
    chk("drop_cnt6", dc6d, 6);
    chk("drop_sat", dc6c, 3);
    chk("stall_busy", busy6s, 1);
    chk("stall_srdy", b6s.s_ready, 0);
    chk("stall_cnt", dc6s, 0);

    // escape the stall by selecting channel 1
    sw6 = 1; mr6 = 6'b000010;
    @(negedge clock);
    chk("esc_path", cp6s, 1);
    chk("esc_pok", pok6s, 1);
    chk("esc_e0", {b6s.m_valid, b6s.m_data[0]}, {6'h02, 8'hE0});
    @(negedge clock);
    chk("esc_e1", {b6s.m_valid, b6s.m_data[0]}, {6'h02, 8'hE1});
    @(negedge clock);
    chk("esc_empty", busy6s, 0);
    chk("esc_mvld", b6s.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
